if_fetch_stage: RTL
===================

// Module: if_fetch_stage
// PURPOSE
//  Instruction-fetch stage of the 5-stage pipelined MIPS core. Owns the PC and drives the
//  combinational instruction memory address. Selects the next PC from sequential, branch,
//  jump, jr, interrupt and exception sources. Captures the returned word into the IF/ID
//  pipeline register, with stall (hold) and flush (bubble) control.
// PARAMETERS
//  RESET_VEC  32'h8000_0000  PC after reset (kernel mode, bit31=1)
//  IRQ_VEC    32'h8000_0004  interrupt entry
//  EXC_VEC    32'h8000_0008  exception entry
//  NOP_WORD   32'h0000_0000  word loaded into IF/ID on flush
// PORTS
//  clk          in   1   rising-edge clock
//  reset        in   1   asynchronous, active-low reset
//  stall        in   1   load-use hazard from ID: hold PC and IF/ID
//  br_taken     in   1   EX-stage branch resolved taken
//  br_target    in   32  branch target from EX
//  jmp          in   1   ID-stage j/jal decoded
//  jmp_target   in   32  jump target from ID
//  jr           in   1   ID-stage jr/jalr decoded
//  jr_target    in   32  register value for jr
//  exc          in   1   exception request (undefined instr, etc.)
//  irq          in   1   level-sensitive interrupt request from timer/peripherals
//  imem_addr    out  32  = pc, to instruction memory address (word index [9:2])
//  imem_instr   in   32  instruction word, combinational from memory
//  id_instr     out  32  IF/ID instruction
//  id_pc_plus4  out  32  IF/ID pc+4 (link value, branch base)
//  id_valid     out  1   IF/ID holds a real instruction
//  irq_ack      out  1   interrupt taken this cycle (combinational)
//  epc          out  32  return PC for interrupt; valid when irq_ack=1
// BEHAVIOUR
//  - Reset (async, reset=0): pc=RESET_VEC, id_instr=NOP_WORD, id_pc_plus4=0, id_valid=0.
//    irq_ack=0 because pc[31]=1. Release takes effect on the next rising edge.
//  - imem_addr=pc combinationally. Fetch latency is 0 cycles: the word is in IF/ID on the next edge.
//  - irq_take = irq & ~pc[31] & ~exc & ~br_taken & ~stall & ~jmp & ~jr.
//    While blocked, the request is not latched; the source holds its level.
//  - Next-PC priority (highest first), evaluated every cycle:
//    1 exc       -> pc=EXC_VEC, flush
//    2 irq_take  -> pc=IRQ_VEC, flush, irq_ack=1, epc=pc
//    3 br_taken  -> pc={pc[31],br_target[30:0]}, flush (overrides stall)
//    4 stall     -> pc held, IF/ID held, jmp/jr ignored (ID re-decodes next cycle)
//    5 jr        -> pc=jr_target (full 32 bits; only path that clears bit31), flush
//    6 jmp       -> pc={pc[31],jmp_target[30:0]}, flush
//    7 default   -> pc=pc+4, IF/ID loads {imem_instr, pc+4, valid=1}
//  - Flush: IF/ID <= {NOP_WORD, 32'h0, valid=0}. No delay slots.
//  - pc+4 and pc+4 output: 32-bit add with wrap. Bit31 is carried unchanged except on jr/vector.
//  - jr and jmp both asserted (decoder error): jr wins.
//  - pc[1:0] forced to 2'b00 on every load.
// STRUCTURE
//  - Shared header cpu_defs.vh holds: RESET_VEC/IRQ_VEC/EXC_VEC, NOP_WORD, and the
//    next-PC select encoding (PCSEL_SEQ/BR/JR/J/IRQ/EXC). This encoding is shared with the
//    hazard unit.
//  - One sub-module: if_id_reg (IF/ID register with hold/flush inputs).
//  - The PC register and next-PC mux stay in if_fetch_stage.
// TESTING
//  1 Reset low mid-run at pc=0x8000_0010
//    -> imem_addr=0x8000_0000 immediately; id_valid=0, id_instr=0.
//  2 Sequential fetch, memory returns 0x2013_0064 at 0x8000_0000
//    -> next edge: id_instr=0x2013_0064, id_pc_plus4=0x8000_0004, imem_addr=0x8000_0004.
//  3 stall=1 for 2 cycles at pc=0x0000_0018 -> pc and IF/ID unchanged.
//    Same with jmp=1 -> jump ignored until stall drops.
//  4 br_taken=1, br_target=0x0000_0024, stall=1 together at pc=0x0000_0020
//    -> pc=0x0000_0024, id_valid=0.
//  5 irq=1 at pc=0x0000_000C (user mode)
//    -> irq_ack=1, epc=0x0000_000C, pc=0x8000_0004, flush.
//    Same at pc=0x8000_00DC -> no ack, pc=0x8000_00E0.
//  6 exc=1 and br_taken=1 and irq=1 together at user pc
//    -> pc=0x8000_0008, irq_ack=0.
//    Then jr_target=0x0000_0030 -> pc=0x0000_0030 (bit31 cleared).

Source files
------------

// File: rtl/if_fetch_stage_pkg.sv
// Shared fetch-stage definitions: vector addresses, the next-PC select encoding
// (also consumed by the hazard unit) and small PC helper functions.
package if_fetch_stage_pkg;

    localparam logic [31:0] RESET_VEC_DEF = 32'h8000_0000;
    localparam logic [31:0] IRQ_VEC_DEF   = 32'h8000_0004;
    localparam logic [31:0] EXC_VEC_DEF   = 32'h8000_0008;
    localparam logic [31:0] NOP_WORD_DEF  = 32'h0000_0000;

    typedef enum logic [2:0] {
        PCSEL_SEQ = 3'd0,
        PCSEL_BR  = 3'd1,
        PCSEL_JR  = 3'd2,
        PCSEL_J   = 3'd3,
        PCSEL_IRQ = 3'd4,
        PCSEL_EXC = 3'd5
    } pcsel_e;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    // Redirects other than jr and the vectors may not change the kernel/user bit.
    function automatic logic [31:0] keep_mode(input logic [31:0] cur_pc,
                                              input logic [31:0] target);
        return {cur_pc[31], target[30:0]};
    endfunction

endpackage

// File: rtl/if_fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush inserts a bubble, hold freezes the contents.
module if_fetch_stage_if_id_reg
    import if_fetch_stage_pkg::*;
#(
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_hold,
    input  logic        i_flush,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc_plus4,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc_plus4,
    output logic        o_valid
);

    logic [31:0] r_instr;
    logic [31:0] r_pc_plus4;
    logic        r_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_instr    <= NOP_WORD;
            r_pc_plus4 <= 32'h0;
            r_valid    <= 1'b0;
        end else if (i_flush) begin
            r_instr    <= NOP_WORD;
            r_pc_plus4 <= 32'h0;
            r_valid    <= 1'b0;
        end else if (!i_hold) begin
            r_instr    <= i_instr;
            r_pc_plus4 <= i_pc_plus4;
            r_valid    <= 1'b1;
        end
    end

    assign o_instr    = r_instr;
    assign o_pc_plus4 = r_pc_plus4;
    assign o_valid    = r_valid;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, prioritised next-PC selection, interrupt
// acceptance and the IF/ID register. Instruction memory is read combinationally.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = RESET_VEC_DEF,
    parameter logic [31:0] IRQ_VEC   = IRQ_VEC_DEF,
    parameter logic [31:0] EXC_VEC   = EXC_VEC_DEF,
    parameter logic [31:0] NOP_WORD  = NOP_WORD_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jmp,
    input  logic [31:0] jmp_target,
    input  logic        jr,
    input  logic [31:0] jr_target,
    input  logic        exc,
    input  logic        irq,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc_plus4,
    output logic        id_valid,
    output logic        irq_ack,
    output logic [31:0] epc
);

    logic [31:0] r_pc;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_next_pc;
    logic        w_irq_take;
    logic        w_hold;
    logic        w_flush;
    pcsel_e      w_sel;
    logic        w_unused_ok;

    assign w_pc_plus4 = r_pc + 32'd4;

    // Kernel mode (pc[31]=1) masks interrupts; any competing redirect or stall
    // defers the request, which the source keeps asserted until accepted.
    assign w_irq_take = irq & ~r_pc[31] & ~exc & ~br_taken & ~stall & ~jmp & ~jr;

    always_comb begin
        w_sel  = PCSEL_SEQ;
        w_hold = 1'b0;
        if (exc) begin
            w_sel = PCSEL_EXC;
        end else if (w_irq_take) begin
            w_sel = PCSEL_IRQ;
        end else if (br_taken) begin
            w_sel = PCSEL_BR;
        end else if (stall) begin
            w_hold = 1'b1;
        end else if (jr) begin
            w_sel = PCSEL_JR;
        end else if (jmp) begin
            w_sel = PCSEL_J;
        end
    end

    always_comb begin
        w_next_pc = r_pc;
        if (!w_hold) begin
            case (w_sel)
                PCSEL_EXC: w_next_pc = EXC_VEC;
                PCSEL_IRQ: w_next_pc = IRQ_VEC;
                PCSEL_BR:  w_next_pc = keep_mode(r_pc, br_target);
                PCSEL_JR:  w_next_pc = jr_target;
                PCSEL_J:   w_next_pc = keep_mode(r_pc, jmp_target);
                default:   w_next_pc = keep_mode(r_pc, w_pc_plus4);
            endcase
        end
    end

    // Every redirect squashes the word fetched this cycle; there are no delay slots.
    assign w_flush = (w_sel != PCSEL_SEQ);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc <= RESET_VEC;
        end else begin
            r_pc <= word_align(w_next_pc);
        end
    end

    if_fetch_stage_if_id_reg #(
        .NOP_WORD   (NOP_WORD)
    ) u_if_id_reg (
        .clk        (clk),
        .reset      (reset),
        .i_hold     (w_hold),
        .i_flush    (w_flush),
        .i_instr    (imem_instr),
        .i_pc_plus4 (w_pc_plus4),
        .o_instr    (id_instr),
        .o_pc_plus4 (id_pc_plus4),
        .o_valid    (id_valid)
    );

    assign imem_addr   = r_pc;
    assign irq_ack     = w_irq_take;
    assign epc         = r_pc;
    assign w_unused_ok = ^{br_target[31], jmp_target[31]};

endmodule
